// File: rtl/uart_rx_frame_pkg.sv
// uart_rx_frame_pkg: receiver FSM state encoding and baud divider helper shared by the UART blocks
package uart_rx_frame_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} uart_state_t;
    function automatic int uart_div(input int clk_mhz, input int baud, input int os);
        return clk_mhz * 1_000_000 / (baud * os);
    endfunction
endpackage

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: serial line in, valid/ready word out and status flags of the UART receiver
//   rx        serial line, idle high
//   rx_data   received word, stable while valid_out
//   valid_out rx_data holds an unconsumed word
//   ready_in  downstream accepts the word
//   rx_busy   receiver is inside a frame
//   frame_err one-cycle pulse, stop bit low, word dropped
//   overrun   one-cycle pulse, word dropped because holding register was full
//   master: receiver side, slave: line driver / word consumer side
interface uart_rx_frame_if #(parameter int DATA_WIDTH = 8);
    logic                  rx;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  valid_out;
    logic                  ready_in;
    logic                  rx_busy;
    logic                  frame_err;
    logic                  overrun;
    modport master (input rx, ready_in, output rx_data, valid_out, rx_busy, frame_err, overrun);
    modport slave (output rx, ready_in, input rx_data, valid_out, rx_busy, frame_err, overrun);
endinterface

// File: rtl/uart_rx_frame_baud_tick.sv
// uart_baud_tick: oversampling prescaler, counts 0..DIV-1 while en and pulses tick on DIV-1
//   clk, rst  clock, async active-high reset
//   en        count enable
//   clear     force the count back to 0
//   tick      combinational pulse on the last count while enabled
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign tick = en && cnt_q == LAST;
    always_comb cnt_d = clear ? '0 : tick ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling 8N1 UART receiver with a valid/ready holding register
//   clk, rst  clock, async active-high reset
//   bus       uart_rx_frame_if master: rx line in, rx_data/valid_out/ready_in, rx_busy, frame_err, overrun
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int BAUDRATE     = 9600,
    parameter int CLK_FREQ_MHZ = 125,
    parameter int OVERSAMPLE   = 16
) (
    input logic           clk,
    input logic           rst,
    uart_rx_frame_if.master bus
);
    localparam int DIV = uart_div(CLK_FREQ_MHZ, BAUDRATE, OVERSAMPLE);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    uart_state_t           state_q, state_d;
    logic [1:0]            sync_q, sync_d;
    logic                  prev_q;
    logic [OS_W-1:0]       os_q, os_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d, data_q, data_d;
    logic                  valid_q, valid_d, fe_q, fe_d, ov_q, ov_d;
    logic                  rx_s, fall, tick, busy;
    assign rx_s = sync_q[1];
    assign fall = prev_q & ~rx_s;
    assign busy = state_q != IDLE;
    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .clear(~busy),
        .tick (tick)
    );
    always_comb begin
        sync_d  = {sync_q[0], bus.rx};
        state_d = state_q;
        os_d    = os_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = valid_q & ~bus.ready_in;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
        case (state_q)
            IDLE: if (fall) begin
                state_d = START;
                os_d    = '0;
                bit_d   = '0;
            end
            START: if (tick) begin
                os_d = os_q + 1'b1;
                if (os_q == OS_HALF) begin
                    state_d = rx_s ? IDLE : DATA;
                    os_d    = '0;
                end
            end
            DATA: if (tick) begin
                os_d = os_q + 1'b1;
                if (os_q == OS_LAST) begin
                    os_d    = '0;
                    sh_d    = {rx_s, sh_q[DATA_WIDTH-1:1]};
                    bit_d   = bit_q + 1'b1;
                    state_d = bit_q == BIT_LAST ? STOP : DATA;
                end
            end
            default: if (tick) begin
                os_d = os_q + 1'b1;
                // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge
                if (os_q == OS_LAST) begin
                    state_d = IDLE;
                    if (!rx_s) fe_d = 1'b1;
                    else if (!valid_q || bus.ready_in) begin
                        data_d  = sh_q;
                        valid_d = 1'b1;
                    end else ov_d = 1'b1;
                end
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            os_q    <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= rx_s;
            os_q    <= os_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    assign bus.rx_data   = data_q;
    assign bus.valid_out = valid_q;
    assign bus.rx_busy   = busy;
    assign bus.frame_err = fe_q;
    assign bus.overrun   = ov_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed checks of uart_rx_frame at 16 clk per bit
module tb_uart_rx_frame;
    localparam int BIT_CLK = 16;
    // pin-to-valid: mid-start + 9 bits of 16 ticks, one cycle to register, two synchroniser stages
    localparam int LAT = 8 + 9 * 16 + 1 + 2;
    logic clk, rst;
    int n_tests, n_fail, fe_cnt, ov_cnt;
    logic [7:0] got[$];
    uart_rx_frame_if #(.DATA_WIDTH(8)) bus ();
    uart_rx_frame #(
        .DATA_WIDTH  (8),
        .BAUDRATE    (62500),
        .CLK_FREQ_MHZ(1),
        .OVERSAMPLE  (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(negedge clk)
        if (!rst) begin
            if (bus.valid_out && bus.ready_in) got.push_back(bus.rx_data);
            if (bus.frame_err) fe_cnt++;
            if (bus.overrun) ov_cnt++;
        end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic send_byte(input logic [7:0] d, input logic stop);
        bus.rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        bus.rx = stop;
        repeat (BIT_CLK) @(negedge clk);
        bus.rx = 1'b1;
    endtask
    task automatic check_words(input string tag, input logic [7:0] exp[$]);
        check({tag, "_count"}, got.size(), exp.size());
        if (got.size() == exp.size())
            for (int i = 0; i < exp.size(); i++) check($sformatf("%s_word%0d", tag, i), got[i], exp[i]);
        got.delete();
    endtask
    initial begin
        int lat, busy_n, fe0, ov0;
        n_tests = 0;
        n_fail = 0;
        fe_cnt = 0;
        ov_cnt = 0;
        rst = 1'b1;
        bus.rx = 1'b1;
        bus.ready_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rx_data", bus.rx_data, 8'h00);
        check("rst_valid", bus.valid_out, 1'b0);
        check("rst_busy", bus.rx_busy, 1'b0);
        check("rst_frame_err", bus.frame_err, 1'b0);
        check("rst_overrun", bus.overrun, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        // 1: single word and latency
        lat = 0;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                while (lat < 400 && !bus.valid_out) begin
                    @(negedge clk);
                    lat++;
                end
                check("t1_latency", lat, LAT);
                @(negedge clk);
                check("t1_valid_one_cycle", bus.valid_out, 1'b0);
            end
        join
        repeat (20) @(negedge clk);
        check_words("t1", '{8'hA5});
        // 2: start glitch
        fe0 = fe_cnt;
        busy_n = 0;
        fork
            begin
                bus.rx = 1'b0;
                repeat (4) @(negedge clk);
                bus.rx = 1'b1;
            end
            repeat (40) begin
                @(negedge clk);
                busy_n += int'(bus.rx_busy);
            end
        join
        check("t2_busy_cycles", busy_n, 8);
        check("t2_no_frame_err", fe_cnt - fe0, 0);
        check_words("t2", '{});
        // 3: framing error then a good frame
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_byte(8'h3C, 1'b0);
        repeat (20) @(negedge clk);
        check("t3_frame_err", fe_cnt - fe0, 1);
        check_words("t3_bad", '{});
        send_byte(8'h81, 1'b1);
        repeat (20) @(negedge clk);
        check_words("t3_good", '{8'h81});
        check("t3_frame_err_total", fe_cnt - fe0, 1);
        // 4: overrun while stalled
        ov0 = ov_cnt;
        bus.ready_in = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (20) @(negedge clk);
        check("t4_overrun", ov_cnt - ov0, 1);
        check("t4_valid_held", bus.valid_out, 1'b1);
        check("t4_data_held", bus.rx_data, 8'h11);
        @(posedge clk);
        #1 bus.ready_in = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_valid_after", bus.valid_out, 1'b0);
        check_words("t4", '{8'h11});
        // 5: back-to-back frames
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (20) @(negedge clk);
        check_words("t5", '{8'h00, 8'hFF, 8'h55});
        check("t5_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        // 6: reset mid-frame
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        fork
            send_byte(8'h7E, 1'b1);
            begin
                repeat (60) @(negedge clk);
                check("t6_busy_before_rst", bus.rx_busy, 1'b1);
                rst = 1'b1;
                @(negedge clk);
                check("t6_outs_in_rst", {bus.rx_data, bus.valid_out, bus.rx_busy, bus.frame_err, bus.overrun}, 12'h000);
            end
        join
        repeat (5) @(negedge clk);
        check("t6_outs_end_rst", {bus.rx_data, bus.valid_out, bus.rx_busy, bus.frame_err, bus.overrun}, 12'h000);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        send_byte(8'h42, 1'b1);
        repeat (20) @(negedge clk);
        check_words("t6", '{8'h42});
        check("t6_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
